// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared DES sequencer state encoding and block constants
package des_pkg;

  localparam int DES_ROUNDS = 16;
  localparam int DES_BLK_W  = 64;

  typedef enum logic [3:0] {
    IDLE,
    LOAD0,
    LOAD1,
    LOAD2,
    ROUND,
    WR0,
    WR1,
    NEXT,
    DONE
  } des_state_e;

endpackage

// File: rtl/des_cbc_chain.sv
// rtl/des_cbc_chain.sv - CBC chain value, held ciphertext and the encrypt/decrypt XOR muxing
module des_cbc_chain
  import des_pkg::*;
(
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 i_init,
  input  logic [DES_BLK_W-1:0] i_iv,
  input  logic                 i_decrypt,
  input  logic                 i_load,
  input  logic [DES_BLK_W-1:0] i_block,
  input  logic                 i_finish,
  input  logic [DES_BLK_W-1:0] i_des_out,
  output logic [DES_BLK_W-1:0] o_core_in,
  output logic [DES_BLK_W-1:0] o_result
);

  logic [DES_BLK_W-1:0] r_chain;
  logic [DES_BLK_W-1:0] r_ct_hold;

  // Encrypt whitens before the core; decrypt un-whitens after it.
  assign o_core_in = i_decrypt ? i_block : (i_block ^ r_chain);
  assign o_result  = i_decrypt ? (i_des_out ^ r_chain) : i_des_out;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_chain   <= '0;
      r_ct_hold <= '0;
    end else begin
      if (i_init) begin
        r_chain <= i_iv;
      end else if (i_finish) begin
        r_chain <= i_decrypt ? r_ct_hold : i_des_out;
      end
      if (i_load && i_decrypt) begin
        r_ct_hold <= i_block;
      end
    end
  end

endmodule

// File: rtl/des_cbc_sequencer.sv
// rtl/des_cbc_sequencer.sv - CBC-mode block sequencer around the shared 16-round DES core
module des_cbc_sequencer
  import des_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int BLOCKS = 256
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 decrypt,
  input  logic [DES_BLK_W-1:0] iv,
  output logic [ADDR_W-1:0]    ram_i_addr,
  input  logic [31:0]          ram_i_dout,
  output logic [ADDR_W-1:0]    ram_o_addr,
  output logic [31:0]          ram_o_din,
  output logic                 ram_o_we,
  output logic [DES_BLK_W-1:0] des_in,
  output logic [3:0]           des_round_sel,
  input  logic [DES_BLK_W-1:0] des_out,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADDR_W-2:0] LAST_BLK   = (ADDR_W-1)'(BLOCKS - 1);
  localparam logic [3:0]        LAST_ROUND = 4'(DES_ROUNDS - 1);

  des_state_e r_state, w_state_next;

  logic [ADDR_W-1:0]    r_rd_ptr;
  logic [ADDR_W-1:0]    r_wr_ptr;
  logic [ADDR_W-2:0]    r_blk;
  logic                 r_decrypt;
  logic [31:0]          r_lo;
  logic [DES_BLK_W-1:0] r_des_in;
  logic [3:0]           r_round_sel;
  logic [DES_BLK_W-1:0] r_result;

  logic                 w_start;
  logic                 w_last_round;
  logic [DES_BLK_W-1:0] w_block;
  logic [DES_BLK_W-1:0] w_core_in;
  logic [DES_BLK_W-1:0] w_result;

  assign w_start      = (r_state == IDLE) && start;
  assign w_last_round = (r_state == ROUND) && (r_round_sel == LAST_ROUND);
  assign w_block      = {ram_i_dout, r_lo};

  des_cbc_chain u_chain (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .i_init    (w_start),
    .i_iv      (iv),
    .i_decrypt (r_decrypt),
    .i_load    (r_state == LOAD2),
    .i_block   (w_block),
    .i_finish  (w_last_round),
    .i_des_out (des_out),
    .o_core_in (w_core_in),
    .o_result  (w_result)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = LOAD0;
      LOAD0:   w_state_next = LOAD1;
      LOAD1:   w_state_next = LOAD2;
      LOAD2:   w_state_next = ROUND;
      ROUND:   if (w_last_round) w_state_next = WR0;
      WR0:     w_state_next = WR1;
      WR1:     w_state_next = NEXT;
      NEXT:    w_state_next = (r_blk == LAST_BLK) ? DONE : LOAD0;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // The read address follows rd_ptr directly so the 1-cycle RAM latency lines up with LOAD1/LOAD2.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_blk       <= '0;
      r_decrypt   <= 1'b0;
      r_lo        <= '0;
      r_des_in    <= '0;
      r_round_sel <= '0;
      r_result    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_blk     <= '0;
            r_decrypt <= decrypt;
          end
        end
        LOAD0: r_rd_ptr <= r_rd_ptr + 1'b1;
        LOAD1: begin
          r_lo     <= ram_i_dout;
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        LOAD2: begin
          r_des_in    <= w_core_in;
          r_round_sel <= '0;
        end
        ROUND: begin
          if (r_round_sel == LAST_ROUND) begin
            r_result <= w_result;
          end else begin
            r_round_sel <= r_round_sel + 1'b1;
          end
        end
        WR0, WR1: r_wr_ptr <= r_wr_ptr + 1'b1;
        NEXT: begin
          if (r_blk != LAST_BLK) begin
            r_blk <= r_blk + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ram_o_we  = 1'b0;
    ram_o_din = '0;
    case (r_state)
      WR0: begin
        ram_o_we  = 1'b1;
        ram_o_din = r_result[31:0];
      end
      WR1: begin
        ram_o_we  = 1'b1;
        ram_o_din = r_result[63:32];
      end
      default: ;
    endcase
  end

  assign ram_i_addr    = r_rd_ptr;
  assign ram_o_addr    = r_wr_ptr;
  assign des_in        = r_des_in;
  assign des_round_sel = r_round_sel;
  assign busy          = (r_state != IDLE);
  assign done          = (r_state == DONE);

endmodule
